// File: rtl/ctrl_pipe_reg.sv
// Generic pipeline stage register with a ready/valid handshake and a 2-entry skid buffer.
// in_ready is registered, so stalling the upstream stage never sees a combinational path from out_ready.
module ctrl_pipe_reg #(
    parameter int                 WIDTH  = 4,
    parameter logic [WIDTH-1:0]   BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] s_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic acc;
    logic pop;

    assign acc = in_valid & in_ready_reg & ~flush;
    assign pop = out_valid_reg & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            m_reg         <= BUBBLE;
            s_reg         <= BUBBLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= EMPTY;
            m_reg         <= BUBBLE;
            s_reg         <= BUBBLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        m_reg         <= din;
                        state_reg     <= ONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        m_reg <= din;
                    end else if (acc) begin
                        // Second entry parks in the skid register; M keeps the older one.
                        s_reg        <= din;
                        state_reg    <= FULL;
                        in_ready_reg <= 1'b0;
                    end else if (pop) begin
                        m_reg         <= BUBBLE;
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_reg        <= s_reg;
                        s_reg        <= BUBBLE;
                        state_reg    <= ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    m_reg         <= BUBBLE;
                    s_reg         <= BUBBLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign dout      = m_reg;
    assign level     = 2'(state_reg);

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Bench for ctrl_pipe_reg: directed scenarios plus random traffic checked against a queue model.
module tb_ctrl_pipe_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] dout;
    logic [1:0] level;

    logic       in_valid6;
    logic       in_ready6;
    logic [5:0] din6;
    logic       out_valid6;
    logic       out_ready6;
    logic [5:0] dout6;
    logic [1:0] level6;

    always #5 clk = ~clk;

    ctrl_pipe_reg #(.WIDTH(4), .BUBBLE(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .level(level)
    );

    ctrl_pipe_reg #(.WIDTH(6), .BUBBLE(6'h2A)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid6), .in_ready(in_ready6), .din(din6),
        .out_valid(out_valid6), .out_ready(out_ready6), .dout(dout6), .level(level6)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the stage is a FIFO of capacity 2.
    logic [3:0] q[$];
    bit         m_in_ready = 1'b1;
    bit         prev_pending = 1'b0;
    logic [3:0] prev_din = 4'h0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, q.size() != 0});
        chk({tag, ".dout"}, {4'd0, dout}, {4'd0, (q.size() != 0) ? q[0] : 4'h0});
        chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, m_in_ready});
        chk({tag, ".level"}, {6'd0, level}, 8'(q.size()));
    endtask

    task automatic model_reset();
        q.delete();
        m_in_ready   = 1'b1;
        prev_pending = 1'b0;
    endtask

    task automatic step(input string tag, input bit iv, input logic [3:0] d,
                        input bit ordy, input bit fl, output bit accepted);
        bit pop;
        @(negedge clk);
        // An unaccepted, unflushed offer must be held unchanged.
        if (prev_pending)
            chk({tag, ".hold"}, {3'd0, iv, d}, {3'd0, 1'b1, prev_din});
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        #1 out_ready = ~ordy;
        #1 chk({tag, ".ready_indep"}, {7'd0, in_ready}, {7'd0, m_in_ready});
        out_ready = ordy;
        @(posedge clk);
        accepted = iv && m_in_ready && !fl;
        pop      = (q.size() != 0) && ordy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (accepted) q.push_back(d);
        end
        m_in_ready   = (q.size() < 2);
        prev_pending = iv && !accepted && !fl;
        prev_din     = d;
        #1 check_outputs(tag);
    endtask

    initial begin
        bit         a;
        bit         pend_v;
        logic [3:0] pend_d;
        bit         fl;
        bit         ordy;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; din = 4'h0; out_ready = 1'b0;
        in_valid6 = 1'b0; din6 = 6'h0; out_ready6 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs("reset");
        chk("reset.dout6", {2'd0, dout6}, 8'h2A);
        @(negedge clk);
        rst_n = 1'b1;

        // Bubble parameter on the 6-bit instance; the 4-bit instance idles empty.
        @(posedge clk); #1;
        chk("bubble.idle_dout6", {2'd0, dout6}, 8'h2A);
        chk("bubble.idle_ov6", {7'd0, out_valid6}, 8'h0);
        @(negedge clk);
        in_valid6 = 1'b1; din6 = 6'h15; out_ready6 = 1'b0;
        @(posedge clk); #1;
        chk("bubble.acc_dout6", {2'd0, dout6}, 8'h15);
        chk("bubble.acc_ov6", {7'd0, out_valid6}, 8'h1);
        @(negedge clk);
        in_valid6 = 1'b0; out_ready6 = 1'b1;
        @(posedge clk); #1;
        chk("bubble.pop_dout6", {2'd0, dout6}, 8'h2A);
        chk("bubble.pop_ov6", {7'd0, out_valid6}, 8'h0);
        chk("bubble.pop_level6", {6'd0, level6}, 8'h0);

        // Streaming at one entry per cycle.
        for (int i = 1; i <= 4; i++) begin
            step("stream", 1'b1, 4'(i), 1'b1, 1'b0, a);
            chk("stream.val", {4'd0, dout}, 8'(i));
            chk("stream.level", {6'd0, level}, 8'h1);
        end
        step("stream_drain", 1'b0, 4'h0, 1'b1, 1'b0, a);

        // Backpressure fills the skid register.
        step("skid_a", 1'b1, 4'h5, 1'b1, 1'b0, a);
        step("skid_b", 1'b1, 4'h6, 1'b0, 1'b0, a);
        chk("skid.level", {6'd0, level}, 8'h2);
        chk("skid.in_ready", {7'd0, in_ready}, 8'h0);
        chk("skid.dout", {4'd0, dout}, 8'h5);
        step("skid_pop1", 1'b0, 4'h0, 1'b1, 1'b0, a);
        chk("skid.dout2", {4'd0, dout}, 8'h6);
        step("skid_pop2", 1'b0, 4'h0, 1'b1, 1'b0, a);
        chk("skid.empty_ov", {7'd0, out_valid}, 8'h0);

        // Flush while full drops the offer made in the flush cycle.
        step("flush_a", 1'b1, 4'h7, 1'b0, 1'b0, a);
        step("flush_b", 1'b1, 4'h8, 1'b0, 1'b0, a);
        step("flush", 1'b1, 4'h9, 1'b0, 1'b1, a);
        chk("flush.level", {6'd0, level}, 8'h0);
        chk("flush.ov", {7'd0, out_valid}, 8'h0);
        step("flush_after", 1'b0, 4'h0, 1'b1, 1'b0, a);

        // Asynchronous reset mid-cycle while full and holding 4'hA.
        step("rst_fill1", 1'b1, 4'h1, 1'b0, 1'b0, a);
        step("rst_fill2", 1'b1, 4'h2, 1'b0, 1'b0, a);
        step("rst_hold", 1'b1, 4'hA, 1'b0, 1'b0, a);
        @(negedge clk);
        in_valid = 1'b1; din = 4'hA; out_ready = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.dout6", {2'd0, dout6}, 8'h2A);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst", 1'b1, 4'hA, 1'b1, 1'b0, a);
        chk("post_rst.dout", {4'd0, dout}, 8'hA);
        step("post_rst_drain", 1'b0, 4'h0, 1'b1, 1'b0, a);

        // Random traffic with a well-behaved upstream that holds its offer.
        pend_v = 1'b0;
        pend_d = 4'h0;
        for (int n = 0; n < 10000; n++) begin
            if (!pend_v && ($urandom_range(99) < 70)) begin
                pend_v = 1'b1;
                pend_d = 4'($urandom);
            end
            fl   = ($urandom_range(99) < 10);
            ordy = ($urandom_range(99) < 60);
            step("rand", pend_v, pend_v ? pend_d : 4'($urandom), ordy, fl, a);
            if (a || fl) pend_v = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
